rv32_core: RTL and testbench
============================

// Module: rv32_core
// PURPOSE
//  Compact multicycle RV32I core (no pipeline) with private 4096x32 instruction and data RAMs.
//  Each RAM has a second debug port so the bench can preload programs/data and dump memory.
//  Sits at the top of the CPU subsystem; only clock, reset and the two debug ports are external.
// PARAMETERS
//  BRAM_WORDS  4096  words per RAM; the word index is addr[13:2]; higher address bits are ignored (wrap).
//  RESET_PC    0     fetch address after reset release.
// PORTS
//  CPU_CLK               in   1   single clock; all state updates on the rising edge.
//  CPU_RST               in   1   asynchronous, active-low reset.
//  CPU_Debug_DataRAM_A2  in   32  byte address of data RAM port 2.
//  CPU_Debug_DataRAM_WD2 in   32  write data, data RAM port 2.
//  CPU_Debug_DataRAM_WE2 in   4   byte write enables (bit i -> bits 8i+7:8i), data RAM port 2.
//  CPU_Debug_DataRAM_RD2 out  32  registered read data, data RAM port 2.
//  CPU_Debug_InstRAM_A2/WD2/WE2/RD2  same as the four data RAM lines, for the instruction RAM.
// BEHAVIOUR
//  Reset (CPU_RST=0): PC<=RESET_PC, FSM<=FETCH, x1..x31<=0. RAM contents are not cleared.
//  Both debug ports work regardless of reset state. The bench loads memory while reset is held.
//  Debug ports: write on the clock edge when WE2!=0. RD2 is the word at A2 as of the previous edge (1-cycle latency).
//  Debug read-during-write on the same port returns the old data.
//  A2=0xFFFFFFFC maps to word 4095.
//  Same word written in the same cycle by the core (port 1) and debug (port 2): port 2 wins on overlapping bytes.
//  FSM has 3 states:
//  - FETCH: drive PC to inst RAM port 1 (read-only for the core); go to EXEC.
//  - EXEC: decode the instruction, read rs1/rs2, compute the ALU result and next PC.
//    Non-load instructions: write rd, update PC, go to FETCH.
//    Loads: present the address, go to LOAD.
//  - LOAD: extract and extend the load data, write rd, PC<=PC+4, go to FETCH.
//  Timing: 2 cycles per instruction, 3 per load.
//  ISA: LUI, AUIPC, JAL, JALR (target &~1), BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP.
//  Shifts use the low 5 bits; SRA/SRAI are arithmetic. All arithmetic wraps mod 2^32.
//  x0 always reads 0; writes to it are discarded. rd is written on the EXEC/LOAD edge.
//  Register-file reads in the following EXEC see the new value.
//  Stores: byte enables come from addr[1:0] (SB) or addr[1] (SH), with data replicated across lanes; write happens in EXEC.
//  Loads select the byte/half from addr[1:0] and sign- or zero-extend.
//  Misaligned word/half: low address bits are ignored (aligned down); no trap.
//  FENCE, ECALL, EBREAK, CSR and unknown opcodes execute as NOP (PC+4).
//  Branch/jump targets are taken modulo memory size; there is no halt state. Programs end in a self-loop.
//  Reset asserted mid-instruction aborts it immediately. Any in-flight store not yet clocked is lost.
// TESTING
//  - Debug write 0x12345678 to data addr 0x10 (WE2=1111), then read addr 0x10 -> RD2=0x12345678 one cycle later. Addr 0x4010 aliases to the same word.
//  - Partial write: WE2=0010, WD2=0x0000AB00 to a word holding 0x12345678 -> reads 0x1234AB78.
//  - Program addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sw x3,0(x0); self-loop -> data word 0 = 0x0000000C.
//    Each instruction takes 2 cycles after reset release.
//  - Loop: addi x1,x0,10; loop: addi x1,x1,-1; bne x1,x0,loop; sw x1,4(x0) -> word 1 = 0, completes within 70 cycles.
//  - Loads: word 0=0x80FF7F01; lb x5,1(x0)->0x0000007F; lb x6,3(x0)->0xFFFFFF80; lhu x7,2(x0)->0x000080FF.
//    Store each result with sw and check.
//  - Hold CPU_RST=0 mid-run for one cycle, then release: execution restarts at PC 0 with registers cleared.
//    Final memory image equals a clean run.

Source files
------------

// File: rtl/rv32_core.sv
// Compact multicycle RV32I core: FETCH / EXEC / LOAD, no pipeline.
// Private instruction and data RAMs, each with a byte-writable debug port.
module rv32_core #(
  parameter int unsigned BRAM_WORDS = 4096,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] CPU_Debug_DataRAM_A2,
  input  logic [31:0] CPU_Debug_DataRAM_WD2,
  input  logic [3:0]  CPU_Debug_DataRAM_WE2,
  output logic [31:0] CPU_Debug_DataRAM_RD2,
  input  logic [31:0] CPU_Debug_InstRAM_A2,
  input  logic [31:0] CPU_Debug_InstRAM_WD2,
  input  logic [3:0]  CPU_Debug_InstRAM_WE2,
  output logic [31:0] CPU_Debug_InstRAM_RD2
);

  localparam int unsigned AW = $clog2(BRAM_WORDS);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef enum logic [1:0] {StFetch, StExec, StLoad} state_e;

  state_e      state, stateD;
  logic [31:0] pc, pcD, pcPlus4;
  logic [31:0] instWord;
  logic [31:0] regs [32];
  logic [31:0] instMem [BRAM_WORDS];
  logic [31:0] dataMem [BRAM_WORDS];
  logic [31:0] dataRd1;

  logic        rfWe;
  logic [31:0] rfWd;
  logic [3:0]  dWe;
  logic [31:0] dWd;
  logic [31:0] loadVal;

  // Decode fields
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1Idx, rs2Idx;
  logic [2:0]  funct3;
  logic [31:0] immI, immS, immB, immU, immJ;
  logic [31:0] rs1Val, rs2Val, dataAddr;

  assign opcode = instWord[6:0];
  assign rd     = instWord[11:7];
  assign funct3 = instWord[14:12];
  assign rs1Idx = instWord[19:15];
  assign rs2Idx = instWord[24:20];
  assign immI   = {{20{instWord[31]}}, instWord[31:20]};
  assign immS   = {{20{instWord[31]}}, instWord[31:25], instWord[11:7]};
  assign immB   = {{19{instWord[31]}}, instWord[31], instWord[7], instWord[30:25],
                   instWord[11:8], 1'b0};
  assign immU   = {instWord[31:12], 12'b0};
  assign immJ   = {{11{instWord[31]}}, instWord[31], instWord[19:12], instWord[20],
                   instWord[30:21], 1'b0};

  assign rs1Val   = regs[rs1Idx];
  assign rs2Val   = regs[rs2Idx];
  assign pcPlus4  = pc + 32'd4;
  assign dataAddr = rs1Val + ((opcode == OpStore) ? immS : immI);

  logic unusedBits;
  assign unusedBits = ^{dataAddr[31:AW+2], CPU_Debug_DataRAM_A2[31:AW+2],
                        CPU_Debug_DataRAM_A2[1:0], CPU_Debug_InstRAM_A2[31:AW+2],
                        CPU_Debug_InstRAM_A2[1:0]};

  function automatic logic [31:0] aluOp(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic alt);
    logic [31:0] r;
    r = '0;
    case (f3)
      3'd0: r = alt ? (a - b) : (a + b);
      3'd1: r = a << b[4:0];
      3'd2: r = {31'b0, $signed(a) < $signed(b)};
      3'd3: r = {31'b0, a < b};
      3'd4: r = a ^ b;
      3'd5: begin
        if (alt) r = $signed(a) >>> b[4:0];
        else     r = a >> b[4:0];
      end
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic branchTaken(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] f3);
    logic t;
    case (f3)
      3'd0: t = (a == b);
      3'd1: t = (a != b);
      3'd4: t = ($signed(a) < $signed(b));
      3'd5: t = ($signed(a) >= $signed(b));
      3'd6: t = (a < b);
      3'd7: t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Load lane select; address is recomputed in LOAD since rs1 cannot change meanwhile
  always_comb begin
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    byteSel = dataRd1[8*dataAddr[1:0] +: 8];
    halfSel = dataAddr[1] ? dataRd1[31:16] : dataRd1[15:0];
    case (funct3)
      3'd0:    loadVal = {{24{byteSel[7]}}, byteSel};
      3'd1:    loadVal = {{16{halfSel[15]}}, halfSel};
      3'd4:    loadVal = {24'b0, byteSel};
      3'd5:    loadVal = {16'b0, halfSel};
      default: loadVal = dataRd1;
    endcase
  end

  always_comb begin
    stateD = state;
    pcD    = pc;
    rfWe   = 1'b0;
    rfWd   = '0;
    dWe    = '0;
    dWd    = '0;
    unique case (state)
      StFetch: stateD = StExec;
      StExec: begin
        stateD = StFetch;
        pcD    = pcPlus4;
        case (opcode)
          OpLui:   begin rfWe = 1'b1; rfWd = immU; end
          OpAuipc: begin rfWe = 1'b1; rfWd = pc + immU; end
          OpJal:   begin rfWe = 1'b1; rfWd = pcPlus4; pcD = pc + immJ; end
          OpJalr: begin
            rfWe = 1'b1;
            rfWd = pcPlus4;
            pcD  = (rs1Val + immI) & ~32'd1;
          end
          OpBranch: if (branchTaken(rs1Val, rs2Val, funct3)) pcD = pc + immB;
          OpLoad: begin stateD = StLoad; pcD = pc; end
          OpStore: begin
            case (funct3)
              3'd0: begin dWe = 4'b0001 << dataAddr[1:0]; dWd = {4{rs2Val[7:0]}}; end
              3'd1: begin dWe = dataAddr[1] ? 4'b1100 : 4'b0011; dWd = {2{rs2Val[15:0]}}; end
              3'd2: begin dWe = 4'b1111; dWd = rs2Val; end
              default: ;
            endcase
          end
          OpImm: begin
            rfWe = 1'b1;
            rfWd = aluOp(rs1Val, immI, funct3, (funct3 == 3'd5) && instWord[30]);
          end
          OpReg: begin
            rfWe = 1'b1;
            rfWd = aluOp(rs1Val, rs2Val, funct3, instWord[30]);
          end
          default: ;
        endcase
      end
      StLoad: begin
        rfWe   = 1'b1;
        rfWd   = loadVal;
        pcD    = pcPlus4;
        stateD = StFetch;
      end
      default: stateD = StFetch;
    endcase
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST) begin
    if (!CPU_RST) begin
      state <= StFetch;
      pc    <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state <= stateD;
      pc    <= pcD;
      if (rfWe && (rd != 5'd0)) regs[rd] <= rfWd;
    end
  end

  // Instruction RAM: port 1 read-only for the core, port 2 debug
  always_ff @(posedge CPU_CLK) begin
    if (state == StFetch) instWord <= instMem[pc[AW+1:2]];
    for (int i = 0; i < 4; i++) begin
      if (CPU_Debug_InstRAM_WE2[i]) begin
        instMem[CPU_Debug_InstRAM_A2[AW+1:2]][8*i +: 8] <= CPU_Debug_InstRAM_WD2[8*i +: 8];
      end
    end
    CPU_Debug_InstRAM_RD2 <= instMem[CPU_Debug_InstRAM_A2[AW+1:2]];
  end

  // Data RAM: port 2 is written last so it wins on overlapping bytes
  always_ff @(posedge CPU_CLK) begin
    dataRd1 <= dataMem[dataAddr[AW+1:2]];
    for (int i = 0; i < 4; i++) begin
      if (dWe[i]) dataMem[dataAddr[AW+1:2]][8*i +: 8] <= dWd[8*i +: 8];
      if (CPU_Debug_DataRAM_WE2[i]) begin
        dataMem[CPU_Debug_DataRAM_A2[AW+1:2]][8*i +: 8] <= CPU_Debug_DataRAM_WD2[8*i +: 8];
      end
    end
    CPU_Debug_DataRAM_RD2 <= dataMem[CPU_Debug_DataRAM_A2[AW+1:2]];
  end

endmodule

// File: tb/tb_rv32_core.sv
// Directed bench for rv32_core: debug-port behaviour, small programs, reset abort.
module tb_rv32_core;

  logic        CPU_CLK;
  logic        CPU_RST;
  logic [31:0] dA2, dWD2, dRD2, iA2, iWD2, iRD2;
  logic [3:0]  dWE2, iWE2;

  int errors = 0;
  int checks = 0;

  rv32_core dut (
    .CPU_CLK              (CPU_CLK),
    .CPU_RST              (CPU_RST),
    .CPU_Debug_DataRAM_A2 (dA2),
    .CPU_Debug_DataRAM_WD2(dWD2),
    .CPU_Debug_DataRAM_WE2(dWE2),
    .CPU_Debug_DataRAM_RD2(dRD2),
    .CPU_Debug_InstRAM_A2 (iA2),
    .CPU_Debug_InstRAM_WD2(iWD2),
    .CPU_Debug_InstRAM_WE2(iWE2),
    .CPU_Debug_InstRAM_RD2(iRD2)
  );

  initial CPU_CLK = 1'b0;
  always #5 CPU_CLK = ~CPU_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic dataWrite(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] we);
    @(negedge CPU_CLK);
    dA2 = addr; dWD2 = data; dWE2 = we;
    @(posedge CPU_CLK); #1;
    dWE2 = 4'b0;
  endtask

  task automatic dataRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge CPU_CLK);
    dA2 = addr; dWE2 = 4'b0;
    @(posedge CPU_CLK); #1;
    data = dRD2;
  endtask

  task automatic instWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge CPU_CLK);
    iA2 = addr; iWD2 = data; iWE2 = 4'b1111;
    @(posedge CPU_CLK); #1;
    iWE2 = 4'b0;
  endtask

  task automatic instRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge CPU_CLK);
    iA2 = addr; iWE2 = 4'b0;
    @(posedge CPU_CLK); #1;
    data = iRD2;
  endtask

  task automatic holdReset();
    @(negedge CPU_CLK);
    CPU_RST = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge CPU_CLK);
    CPU_RST = 1'b1;
  endtask

  logic [31:0] rd;
  logic [31:0] prog1 [5] = '{32'h00500093, 32'h00700113, 32'h002081B3, 32'h00302023,
                             32'h0000006F};
  logic [31:0] prog2 [5] = '{32'h00A00093, 32'hFFF08093, 32'hFE009EE3, 32'h00102223,
                             32'h0000006F};
  logic [31:0] prog3 [14] = '{32'h00100283, 32'h00300303, 32'h00205383, 32'h00201403,
                              32'h40435493, 32'h12345537, 32'h00502223, 32'h00602423,
                              32'h00702623, 32'h00802823, 32'h00500AA3, 32'h00902C23,
                              32'h00A02E23, 32'h0000006F};
  logic [31:0] prog4 [5] = '{32'h00308093, 32'h00410113, 32'h002081B3, 32'h00302023,
                             32'h0000006F};
  logic [31:0] loadExp [7] = '{32'h0000007F, 32'hFFFFFF80, 32'h000080FF, 32'hFFFF80FF,
                               32'h00007F00, 32'hFFFFFFF8, 32'h12345000};

  initial begin
    CPU_RST = 1'b0;
    dA2 = '0; dWD2 = '0; dWE2 = '0;
    iA2 = '0; iWD2 = '0; iWE2 = '0;
    repeat (2) @(posedge CPU_CLK);

    // Debug port behaviour, reset held throughout
    dataWrite(32'h10, 32'h12345678, 4'b1111);
    dataRead(32'h10, rd);   check("dbg_rd_0x10", rd, 32'h12345678);
    dataRead(32'h4010, rd); check("dbg_alias_0x4010", rd, 32'h12345678);
    dataWrite(32'h10, 32'h0000AB00, 4'b0010);
    dataRead(32'h10, rd);   check("dbg_partial", rd, 32'h1234AB78);
    dataWrite(32'h3FFC, 32'hCAFEF00D, 4'b1111);
    dataRead(32'hFFFFFFFC, rd); check("dbg_top_wrap", rd, 32'hCAFEF00D);
    dataWrite(32'h10, 32'h55AA55AA, 4'b1111);
    check("dbg_rdw_old", dRD2, 32'h1234AB78);
    dataRead(32'h10, rd);   check("dbg_rdw_new", rd, 32'h55AA55AA);
    instWrite(32'h20, 32'hA5A5_0F0F);
    instRead(32'h20, rd);   check("inst_dbg_rd", rd, 32'hA5A50F0F);

    // Program 1: nothing executes while reset is held
    for (int i = 0; i < 5; i++) instWrite(32'(4 * i), prog1[i]);
    dataWrite(32'h0, 32'hDEADBEEF, 4'b1111);
    repeat (20) @(posedge CPU_CLK);
    dataRead(32'h0, rd); check("reset_hold_no_exec", rd, 32'hDEADBEEF);
    dataWrite(32'h0, 32'h0, 4'b1111);
    @(negedge CPU_CLK);
    dA2 = 32'h0;
    CPU_RST = 1'b1;
    // sw is the 4th instruction: it writes on edge 8; RD2 shows it after edge 9
    repeat (8) @(posedge CPU_CLK);
    #1 check("prog1_before_sw", dRD2, 32'h0);
    @(posedge CPU_CLK);
    #1 check("prog1_sum", dRD2, 32'h0000000C);

    // Program 2: countdown loop
    holdReset();
    for (int i = 0; i < 5; i++) instWrite(32'(4 * i), prog2[i]);
    dataWrite(32'h4, 32'hFFFFFFFF, 4'b1111);
    release_reset();
    begin
      logic done;
      done = 1'b0;
      for (int c = 0; c < 70 && !done; c++) begin
        dataRead(32'h4, rd);
        if (rd == 32'h0) done = 1'b1;
      end
      check("loop_done_in_70", {31'b0, done}, 32'h1);
      check("loop_word1", rd, 32'h0);
    end

    // Program 3: loads, extension, sb, srai, lui
    holdReset();
    for (int i = 0; i < 14; i++) instWrite(32'(4 * i), prog3[i]);
    dataWrite(32'h0, 32'h80FF7F01, 4'b1111);
    for (int i = 1; i < 8; i++) dataWrite(32'(4 * i), 32'h0, 4'b1111);
    release_reset();
    repeat (60) @(posedge CPU_CLK);
    for (int i = 0; i < 7; i++) begin
      dataRead(32'(4 * (i + 1)), rd);
      check($sformatf("load_word%0d", i + 1), rd, loadExp[i]);
    end

    // Program 4: reset pulse mid-run must clear registers and restart at PC 0
    holdReset();
    for (int i = 0; i < 5; i++) instWrite(32'(4 * i), prog4[i]);
    dataWrite(32'h0, 32'h0, 4'b1111);
    release_reset();
    repeat (5) @(posedge CPU_CLK);
    holdReset();
    release_reset();
    dataRead(32'h0, rd); check("rst_mid_no_store", rd, 32'h0);
    repeat (30) @(posedge CPU_CLK);
    dataRead(32'h0, rd); check("rst_mid_clean_result", rd, 32'h00000007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
